// File: rtl/forwarding_hazard_unit.sv
// Operand-forwarding selectors and load-use stall detection for the EX stage of
// a 5-stage MIPS pipeline, built on a shadow copy of the EX/MEM/WB control fields.
module forwarding_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            forward_a_sel,
  output logic [1:0]            forward_b_sel,
  output logic                  stall,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic [CNT_W-1:0]      stall_count
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } slot_t;

  localparam slot_t BUBBLE = '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d;

  // The WB slot only matters for its destination; the rest is carried for symmetry.
  logic unused_wb_bits;
  assign unused_wb_bits = ^{wb_q.rs, wb_q.rt, wb_q.mem_read};

  // EX/MEM is checked first: it holds the most recent write to the register.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                         input slot_t mem_s, input slot_t wb_s);
    if (src != '0 && mem_s.reg_write && mem_s.rd == src)
      return 2'd2;
    else if (src != '0 && wb_s.reg_write && wb_s.rd == src)
      return 2'd1;
    else
      return 2'd0;
  endfunction

  assign forward_a_sel = fwd_sel(ex_q.rs, mem_q, wb_q);
  assign forward_b_sel = fwd_sel(ex_q.rt, mem_q, wb_q);

  assign stall = !flush && id_valid && ex_q.mem_read && ex_q.rd != '0 &&
                 (ex_q.rd == id_rs || (id_uses_rt && ex_q.rd == id_rt));

  assign pc_write   = ~stall;
  assign ifid_write = ~stall;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    ex_d = BUBBLE;
    if (!(flush || stall || !id_valid)) begin
      ex_d.rs        = id_rs;
      ex_d.rt        = id_uses_rt ? id_rt : '0;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= BUBBLE;
      mem_q       <= BUBBLE;
      wb_q        <= BUBBLE;
      stall_count <= '0;
    end else begin
      // NOTE: non-blocking so all three slots shift from their pre-edge values.
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
      if (stall && stall_count != CNT_MAX)
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Self-checking bench: directed vector table, hand-written stall/reset sequences,
// and random traffic scored against an instruction-history reference model.
module tb_forwarding_hazard_unit;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_uses_rt, id_reg_write, id_mem_read, flush;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [1:0]    sel_a, sel_b, sel_a2, sel_b2;
  logic          stall, pc_write, ifid_write;
  logic          stall2, pc_write2, ifid_write2;
  logic [15:0]   cnt;
  logic [1:0]    cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  forwarding_hazard_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .forward_a_sel(sel_a),
    .forward_b_sel(sel_b), .stall(stall), .pc_write(pc_write),
    .ifid_write(ifid_write), .stall_count(cnt)
  );

  forwarding_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .forward_a_sel(sel_a2),
    .forward_b_sel(sel_b2), .stall(stall2), .pc_write(pc_write2),
    .ifid_write(ifid_write2), .stall_count(cnt2)
  );

  // Reference model: the last three instructions issued into EX, youngest first.
  typedef struct packed {
    logic [AW-1:0] rs, rt, rd;
    logic          rw, mr;
  } instr_t;

  instr_t hist [3];
  int     n_stall;

  typedef struct {
    logic          v;
    logic [AW-1:0] rs, rt;
    logic          ut;
    logic [AW-1:0] rd;
    logic          rw, mr, fl;
    int            ea, eb, es, ec;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(logic v, logic [AW-1:0] rs, logic [AW-1:0] rt, logic ut,
                              logic [AW-1:0] rd, logic rw, logic mr, logic fl,
                              int ea, int eb, int es, int ec);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.ut = ut; r.rd = rd;
    r.rw = rw; r.mr = mr; r.fl = fl;
    r.ea = ea; r.eb = eb; r.es = es; r.ec = ec;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic ut, input logic [AW-1:0] rd, input logic rw,
                       input logic mr, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ut; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 3; i++) hist[i] = '0;
    n_stall = 0;
  endtask

  // Producer one instruction older than the consumer gives 2, two older gives 1.
  function automatic int exp_sel(logic [AW-1:0] src);
    for (int age = 1; age <= 2; age++)
      if (src != 0 && hist[age].rw && hist[age].rd == src) return 3 - age;
    return 0;
  endfunction

  function automatic int exp_stall();
    instr_t ld = hist[0];
    if (flush || !id_valid || !ld.mr || ld.rd == 0) return 0;
    if (ld.rd == id_rs || (id_uses_rt && ld.rd == id_rt)) return 1;
    return 0;
  endfunction

  task automatic model_clock();
    int s = exp_stall();
    hist[2] = hist[1];
    hist[1] = hist[0];
    if (flush || s == 1 || !id_valid) hist[0] = '0;
    else hist[0] = '{rs: id_rs, rt: (id_uses_rt ? id_rt : '0), rd: id_rd,
                     rw: id_reg_write, mr: id_mem_read};
    if (s == 1) n_stall++;
  endtask

  task automatic compare_outputs(input string tag, input int ea, input int eb,
                                 input int es, input int n);
    check({tag, " sel_a"}, int'(sel_a), ea);
    check({tag, " sel_b"}, int'(sel_b), eb);
    check({tag, " stall"}, int'(stall), es);
    check({tag, " pc_write"}, int'(pc_write), 1 - es);
    check({tag, " ifid_write"}, int'(ifid_write), 1 - es);
    check({tag, " count"}, int'(cnt), (n > 65535) ? 65535 : n);
    check({tag, " sat sel_a"}, int'(sel_a2), ea);
    check({tag, " sat stall"}, int'(stall2), es);
    check({tag, " sat count"}, int'(cnt2), (n > 3) ? 3 : n);
  endtask

  task automatic run_cycle_model(input string tag);
    @(negedge clk);
    compare_outputs(tag, exp_sel(hist[0].rs), exp_sel(hist[0].rt), exp_stall(), n_stall);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    // Reset with arbitrary inputs, including a would-be load-use pattern.
    reset = 1'b1;
    drive(1, 8, 8, 1, 8, 1, 1, 0);
    reset_model();
    #3;
    compare_outputs("reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle_model("idle0");
    run_cycle_model("idle1");

    tbl[0]  = mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 3, 4, 1, 6, 1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    tbl[3]  = mk(1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 5, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[7]  = mk(1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 5, 5, 1, 9, 1, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0);
    tbl[11] = mk(1, 1, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 2, 8, 1, 10, 1, 0, 0, 0, 0, 1, 0);
    tbl[13] = mk(1, 2, 8, 1, 10, 1, 0, 0, 0, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    tbl[15] = mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    tbl[16] = mk(1, 0, 0, 1, 11, 1, 0, 0, 0, 0, 0, 1);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[18] = mk(1, 1, 0, 0, 8, 1, 1, 0, 0, 0, 0, 1);
    tbl[19] = mk(1, 8, 3, 1, 12, 1, 0, 1, 0, 0, 0, 1);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Directed vectors: forwarding, priority, load-use, $0 and flush.
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].ut, tbl[i].rd,
            tbl[i].rw, tbl[i].mr, tbl[i].fl);
      @(negedge clk);
      compare_outputs($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].es, tbl[i].ec);
      @(posedge clk);
      model_clock();
      #1;
    end

    // Reset while a stall is being raised.
    drive(1, 1, 0, 0, 9, 1, 1, 0);
    run_cycle_model("midrst lw");
    drive(1, 9, 0, 0, 13, 1, 0, 0);
    @(negedge clk);
    check("midrst stall before", int'(stall), 1);
    #1 reset = 1'b1;
    #1;
    reset_model();
    compare_outputs("midrst during", 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_cycle_model("midrst after");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle_model("midrst idle0");
    run_cycle_model("midrst idle1");

    // Four back-to-back load-use pairs: the 2-bit counter saturates and holds.
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 0, 8, 1, 1, 0);
      run_cycle_model($sformatf("sat%0d lw", k));
      drive(1, 2, 8, 1, 10, 1, 0, 0);
      run_cycle_model($sformatf("sat%0d stall", k));
      run_cycle_model($sformatf("sat%0d resume", k));
    end
    @(negedge clk);
    check("sat count2 held", int'(cnt2), 3);
    check("sat count16", int'(cnt), 4);
    @(posedge clk); model_clock(); #1;

    // Random traffic over a small register set so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 7) != 0), AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
      run_cycle_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
